vbank_arbiter: RTL and testbench

- Shares one single-read/single-write vector bank between NUM_REQ read requesters and NUM_REQ write requesters.
- The read and write paths are arbitrated independently, each with a round-robin pointer. Requesters use valid/ready handshakes.
- Granted read data is returned one cycle later with a one-hot requester tag.
- The block sits between the vector lane / load-store units and the bank, and drives all bank control pins.

---
 rtl/vbank_arbiter.sv | 136 +++++++++++++
 tb/tb_vbank_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vbank_arbiter.sv
// vbank_arbiter
//   Shares one single-read / single-write vector bank between NUM_REQ read
//   requesters and NUM_REQ write requesters. Each path has its own
//   round-robin pointer and drives the bank in the same cycle as its grant.
//   Read data comes back one cycle after the grant, tagged one-hot.
//
// Ports
//   clk, nRST            clock, asynchronous active-low reset
//   rd_req_valid/addr    per-requester read request (addr sliced per requester)
//   rd_req_ready         one-hot read grant (combinational)
//   rd_rsp_valid         one-hot owner of rd_rsp_data (registered)
//   rd_rsp_data          shared response bus, straight from bank_rdata
//   wr_req_valid/addr/data/strb  per-requester write request
//   wr_req_ready         one-hot write grant (combinational)
//   bank_*               bank control, address, data and strobe pins
//
// Handshake: a transfer happens on a posedge where valid and ready are both
// high. A requester keeps valid and payload stable until ready. ready is a
// function of the valids, the round-robin pointers and the read/write row
// hazard only, never of another requester's ready. Read responses have no
// backpressure: the tagged requester must take rd_rsp_data in that cycle.
module vbank_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int INDEX_WIDTH  = 8,
  parameter int NUM_ELEMENTS = 32,
  parameter int DATA_WIDTH   = 16
) (
  input  logic                                       clk,
  input  logic                                       nRST,
  input  logic [NUM_REQ-1:0]                         rd_req_valid,
  input  logic [NUM_REQ*INDEX_WIDTH-1:0]             rd_req_addr,
  output logic [NUM_REQ-1:0]                         rd_req_ready,
  output logic [NUM_REQ-1:0]                         rd_rsp_valid,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0]         rd_rsp_data,
  input  logic [NUM_REQ-1:0]                         wr_req_valid,
  input  logic [NUM_REQ*INDEX_WIDTH-1:0]             wr_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH*NUM_ELEMENTS-1:0] wr_req_data,
  input  logic [NUM_REQ*NUM_ELEMENTS-1:0]            wr_req_strb,
  output logic [NUM_REQ-1:0]                         wr_req_ready,
  output logic                                       bank_ren,
  output logic [INDEX_WIDTH-1:0]                     bank_raddr,
  input  logic [DATA_WIDTH*NUM_ELEMENTS-1:0]         bank_rdata,
  output logic                                       bank_wen,
  output logic [INDEX_WIDTH-1:0]                     bank_waddr,
  output logic [DATA_WIDTH*NUM_ELEMENTS-1:0]         bank_wdata,
  output logic [NUM_ELEMENTS-1:0]                    bank_wstrb
);

  localparam int ROW_W = DATA_WIDTH * NUM_ELEMENTS;
  localparam int PW    = $clog2(NUM_REQ);

  logic [PW-1:0]          rd_ptr, wr_ptr;
  logic [PW-1:0]          rd_win, wr_win;
  logic                   rd_any, wr_any;
  logic                   hazard, rd_go, wr_go;
  logic [INDEX_WIDTH-1:0] rd_addr_sel, wr_addr_sel;

  // Returns {found, index}: first valid requester at or after ptr, wrapping.
  // The index sum stays below 2*NUM_REQ, so one conditional subtract wraps it.
  function automatic logic [PW:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                          input logic [PW-1:0]      p);
    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;
    logic [PW-1:0] win;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, p} + (PW+1)'(k);
      if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
      idx = sum[PW-1:0];
      if (!found && v[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] w);
    return (w == PW'(NUM_REQ - 1)) ? '0 : w + 1'b1;
  endfunction

  always_comb begin
    {rd_any, rd_win} = rr_pick(rd_req_valid, rd_ptr);
    {wr_any, wr_win} = rr_pick(wr_req_valid, wr_ptr);
    rd_addr_sel = rd_req_addr[int'(rd_win)*INDEX_WIDTH +: INDEX_WIDTH];
    wr_addr_sel = wr_req_addr[int'(wr_win)*INDEX_WIDTH +: INDEX_WIDTH];
    // Same-row read and write in one cycle: the write wins and the read
    // retries next cycle, when the bank already holds the new data.
    hazard = rd_any && wr_any && (rd_addr_sel == wr_addr_sel);
    // Grants are gated by nRST so nothing reaches the bank during reset.
    rd_go  = rd_any && !hazard && nRST;
    wr_go  = wr_any && nRST;
  end

  always_comb begin
    rd_req_ready = '0;
    wr_req_ready = '0;
    bank_ren     = 1'b0;
    bank_raddr   = '0;
    bank_wen     = 1'b0;
    bank_waddr   = '0;
    bank_wdata   = '0;
    bank_wstrb   = '0;
    if (rd_go) begin
      rd_req_ready[rd_win] = 1'b1;
      bank_ren             = 1'b1;
      bank_raddr           = rd_addr_sel;
    end
    if (wr_go) begin
      wr_req_ready[wr_win] = 1'b1;
      bank_wen             = 1'b1;
      bank_waddr           = wr_addr_sel;
      bank_wdata           = wr_req_data[int'(wr_win)*ROW_W +: ROW_W];
      bank_wstrb           = wr_req_strb[int'(wr_win)*NUM_ELEMENTS +: NUM_ELEMENTS];
    end
  end

  // The bank returns data one cycle after ren, so the tag is just the
  // registered grant and the data bus is a straight pass-through.
  assign rd_rsp_data = bank_rdata;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      rd_rsp_valid <= '0;
    end else begin
      rd_rsp_valid <= rd_req_ready;
      if (rd_go) rd_ptr <= ptr_next(rd_win);
      if (wr_go) wr_ptr <= ptr_next(wr_win);
    end
  end

endmodule

// File: tb/tb_vbank_arbiter.sv
// tb_vbank_arbiter
//   Directed bench for vbank_arbiter with a behavioural bank attached.
//   The driver applies inputs on the falling edge, checks grants and bank
//   pins 1 time unit later, and queues the response expected on the next
//   falling edge; a monitor pops the queue every falling edge.
module tb_vbank_arbiter;
  localparam int NR = 4;
  localparam int IW = 8;
  localparam int NE = 32;
  localparam int DW = 16;
  localparam int RW = NE * DW;

  logic                 clk = 1'b0;
  logic                 nRST = 1'b0;
  logic [NR-1:0]        rd_req_valid;
  logic [NR*IW-1:0]     rd_req_addr;
  logic [NR-1:0]        rd_req_ready;
  logic [NR-1:0]        rd_rsp_valid;
  logic [RW-1:0]        rd_rsp_data;
  logic [NR-1:0]        wr_req_valid;
  logic [NR*IW-1:0]     wr_req_addr;
  logic [NR*RW-1:0]     wr_req_data;
  logic [NR*NE-1:0]     wr_req_strb;
  logic [NR-1:0]        wr_req_ready;
  logic                 bank_ren;
  logic [IW-1:0]        bank_raddr;
  logic [RW-1:0]        bank_rdata;
  logic                 bank_wen;
  logic [IW-1:0]        bank_waddr;
  logic [RW-1:0]        bank_wdata;
  logic [NE-1:0]        bank_wstrb;

  always #5 clk = ~clk;

  vbank_arbiter #(.NUM_REQ(NR), .INDEX_WIDTH(IW), .NUM_ELEMENTS(NE), .DATA_WIDTH(DW)) dut (
    .clk(clk), .nRST(nRST),
    .rd_req_valid(rd_req_valid), .rd_req_addr(rd_req_addr), .rd_req_ready(rd_req_ready),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .wr_req_valid(wr_req_valid), .wr_req_addr(wr_req_addr), .wr_req_data(wr_req_data),
    .wr_req_strb(wr_req_strb), .wr_req_ready(wr_req_ready),
    .bank_ren(bank_ren), .bank_raddr(bank_raddr), .bank_rdata(bank_rdata),
    .bank_wen(bank_wen), .bank_waddr(bank_waddr), .bank_wdata(bank_wdata),
    .bank_wstrb(bank_wstrb)
  );

  // Row r element e initially holds {r, e}.
  function automatic logic [RW-1:0] pat(input int r);
    logic [RW-1:0] p;
    for (int e = 0; e < NE; e++) p[e*DW +: DW] = {8'(r), 8'(e)};
    return p;
  endfunction

  logic [RW-1:0] mem [256];

  initial begin
    for (int r = 0; r < 256; r++) mem[r] <= pat(r);
  end

  always @(posedge clk) begin
    if (bank_wen)
      for (int e = 0; e < NE; e++)
        if (bank_wstrb[e]) mem[bank_waddr][e*DW +: DW] <= bank_wdata[e*DW +: DW];
    if (bank_ren) bank_rdata <= mem[bank_raddr];
  end

  // Scoreboard
  logic [NR+RW-1:0] exp_q[$];
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    logic [NR+RW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_tag", RW'(rd_rsp_valid), RW'(e[NR+RW-1:RW]));
        if (e[NR+RW-1:RW] != '0) chk("rsp_data", rd_rsp_data, e[RW-1:0]);
      end else if (rd_rsp_valid !== '0) begin
        chk("rsp_unexpected", RW'(rd_rsp_valid), '0);
      end
    end
  end

  // Driver
  task automatic clear_inputs();
    rd_req_valid = '0;
    rd_req_addr  = '0;
    wr_req_valid = '0;
    wr_req_addr  = '0;
    wr_req_data  = '0;
    wr_req_strb  = '0;
  endtask

  task automatic set_rd(input int i, input logic [IW-1:0] a);
    rd_req_valid[i]          = 1'b1;
    rd_req_addr[i*IW +: IW]  = a;
  endtask

  task automatic set_wr(input int i, input logic [IW-1:0] a, input logic [RW-1:0] d,
                        input logic [NE-1:0] s);
    wr_req_valid[i]          = 1'b1;
    wr_req_addr[i*IW +: IW]  = a;
    wr_req_data[i*RW +: RW]  = d;
    wr_req_strb[i*NE +: NE]  = s;
  endtask

  task automatic do_reset();
    #2 nRST = 1'b0;
    #2 nRST = 1'b1;
    @(negedge clk);
  endtask

  // Called right after inputs are applied at a falling edge; returns at the
  // next falling edge. Address/data expectations are 0 when not granted.
  task automatic expect_cyc(input string tag, input logic [NR-1:0] e_rrdy,
                            input logic [NR-1:0] e_wrdy, input logic [IW-1:0] e_raddr,
                            input logic [IW-1:0] e_waddr, input logic [RW-1:0] e_wdata,
                            input logic [NE-1:0] e_wstrb, input logic [RW-1:0] e_rsp);
    #1;
    chk({tag, "_rd_ready"}, RW'(rd_req_ready), RW'(e_rrdy));
    chk({tag, "_wr_ready"}, RW'(wr_req_ready), RW'(e_wrdy));
    chk({tag, "_ren"},      RW'(bank_ren),     RW'(|e_rrdy));
    chk({tag, "_raddr"},    RW'(bank_raddr),   RW'(e_raddr));
    chk({tag, "_wen"},      RW'(bank_wen),     RW'(|e_wrdy));
    chk({tag, "_waddr"},    RW'(bank_waddr),   RW'(e_waddr));
    chk({tag, "_wdata"},    bank_wdata,        e_wdata);
    chk({tag, "_wstrb"},    RW'(bank_wstrb),   RW'(e_wstrb));
    exp_q.push_back({e_rrdy, e_rsp});
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    clear_inputs();
    expect_cyc(tag, '0, '0, '0, '0, '0, '0, '0);
  endtask

  logic [RW-1:0] a5, d4, x4, d5, dw;

  initial begin
    clear_inputs();
    a5 = {NE{16'hA5A5}};
    d4 = {NE{16'hFFFF}};
    d4[15:0] = 16'h1234;
    x4 = pat(3);
    x4[15:0] = 16'h1234;
    d5 = {NE{16'h5A5A}};

    // Reset state: everything held off even with every valid high.
    @(negedge clk);
    rd_req_valid = '1;
    wr_req_valid = '1;
    #1;
    chk("rst_rd_ready", RW'(rd_req_ready), '0);
    chk("rst_wr_ready", RW'(wr_req_ready), '0);
    chk("rst_ren",      RW'(bank_ren),     '0);
    chk("rst_wen",      RW'(bank_wen),     '0);
    chk("rst_rsp",      RW'(rd_rsp_valid), '0);
    chk("rst_waddr",    RW'(bank_waddr),   '0);
    chk("rst_wdata",    bank_wdata,        '0);
    chk("rst_wstrb",    RW'(bank_wstrb),   '0);
    clear_inputs();
    @(negedge clk);
    nRST = 1'b1;
    @(negedge clk);

    // Single read, requester 2, row 5.
    do_reset();
    set_rd(2, 8'd5);
    expect_cyc("t1", 4'b0100, '0, 8'd5, '0, '0, '0, pat(5));
    idle("t1_idle");

    // Round robin over four held read requests, then pointer hold.
    do_reset();
    for (int i = 0; i < NR; i++) set_rd(i, 8'(10 + i));
    expect_cyc("t2_g0", 4'b0001, '0, 8'd10, '0, '0, '0, pat(10));
    expect_cyc("t2_g1", 4'b0010, '0, 8'd11, '0, '0, '0, pat(11));
    expect_cyc("t2_g2", 4'b0100, '0, 8'd12, '0, '0, '0, pat(12));
    expect_cyc("t2_g3", 4'b1000, '0, 8'd13, '0, '0, '0, pat(13));
    expect_cyc("t2_g4", 4'b0001, '0, 8'd10, '0, '0, '0, pat(10));
    idle("t2_idle");
    for (int i = 0; i < NR; i++) set_rd(i, 8'(10 + i));
    expect_cyc("t2_hold", 4'b0010, '0, 8'd11, '0, '0, '0, pat(11));
    idle("t2_idle2");

    // Same-row read and write: write first, read retries and sees new data.
    do_reset();
    set_wr(0, 8'd9, a5, '1);
    set_rd(1, 8'd9);
    expect_cyc("t3_haz", '0, 4'b0001, '0, 8'd9, a5, '1, '0);
    wr_req_valid = '0;
    expect_cyc("t3_rd", 4'b0010, '0, 8'd9, '0, '0, '0, a5);
    idle("t3_idle");

    // Partial-strobe write to row 3, then read it back.
    set_wr(2, 8'd3, d4, 32'h0000_0001);
    expect_cyc("t4_wr", '0, 4'b0100, '0, 8'd3, d4, 32'h0000_0001, '0);
    clear_inputs();
    set_rd(3, 8'd3);
    expect_cyc("t4_rd", 4'b1000, '0, 8'd3, '0, '0, '0, x4);
    idle("t4_idle");

    // Different rows in the same cycle: both granted.
    set_wr(3, 8'd2, d5, '1);
    set_rd(0, 8'd7);
    expect_cyc("t5", 4'b0001, 4'b1000, 8'd7, 8'd2, d5, '1, pat(7));
    idle("t5_idle");

    // Write-path round robin.
    do_reset();
    for (int i = 0; i < NR; i++) begin
      dw = {NE{16'(i + 1)}};
      set_wr(i, 8'(40 + i), dw, '1);
    end
    expect_cyc("t6_w0", '0, 4'b0001, '0, 8'd40, {NE{16'd1}}, '1, '0);
    expect_cyc("t6_w1", '0, 4'b0010, '0, 8'd41, {NE{16'd2}}, '1, '0);
    expect_cyc("t6_w2", '0, 4'b0100, '0, 8'd42, {NE{16'd3}}, '1, '0);
    idle("t6_idle");

    // Reset right after a read grant: the pending response is dropped.
    set_rd(2, 8'd20);
    #1;
    chk("t7_pre_ready", RW'(rd_req_ready), RW'(4'b0100));
    @(posedge clk);
    #1;
    clear_inputs();
    nRST = 1'b0;
    #1;
    chk("t7_rsp_dropped", RW'(rd_rsp_valid), '0);
    set_rd(0, 8'd1);
    set_wr(0, 8'd1, d5, '1);
    #1;
    chk("t7_rst_rd_ready", RW'(rd_req_ready), '0);
    chk("t7_rst_wr_ready", RW'(wr_req_ready), '0);
    chk("t7_rst_ren",      RW'(bank_ren),     '0);
    chk("t7_rst_wen",      RW'(bank_wen),     '0);
    clear_inputs();
    @(negedge clk);
    nRST = 1'b1;
    set_rd(1, 8'd21);
    set_rd(2, 8'd22);
    expect_cyc("t7_post", 4'b0010, '0, 8'd21, '0, '0, '0, pat(21));
    idle("t7_idle");

    // Move both pointers to 2, reset, and confirm both restart at 0.
    set_rd(1, 8'd30);
    set_wr(1, 8'd31, d5, '1);
    expect_cyc("t8_pre", 4'b0010, 4'b0010, 8'd30, 8'd31, d5, '1, pat(30));
    clear_inputs();
    do_reset();
    set_rd(1, 8'd21);
    set_rd(2, 8'd22);
    set_wr(1, 8'd50, d5, '1);
    set_wr(2, 8'd51, a5, '1);
    expect_cyc("t8_post", 4'b0010, 4'b0010, 8'd21, 8'd50, d5, '1, pat(21));
    idle("t8_idle");
    idle("end_idle");

    @(negedge clk);
    chk("queue_drained", RW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
